// File: rtl/washer_pkg.sv
// Shared washer definitions: state codes, load codes, actuator bundle.
// Used by the controller, washerTimer and their benches.
package washer_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FILL_W  = 4'd1,
    S_WASH    = 4'd2,
    S_DRAIN_W = 4'd3,
    S_FILL_R  = 4'd4,
    S_RINSE   = 4'd5,
    S_DRAIN_R = 4'd6,
    S_SPIN    = 4'd7,
    S_DONE    = 4'd8,
    S_PAUSE   = 4'd9
  } state_t;

  localparam logic [1:0] LOAD_SMALL = 2'b00;
  localparam logic [1:0] LOAD_MED   = 2'b01;
  localparam logic [1:0] LOAD_LARGE = 2'b10;

  typedef struct packed {
    logic fill_valve;
    logic agitate;
    logic drain_pump;
    logic spin_motor;
    logic door_lock;
    logic done;
  } act_t;

  function automatic logic [1:0] load_of(
    input logic [1:0] sel
  );
    return (sel == 2'b11) ? LOAD_LARGE : sel;
  endfunction

  function automatic logic timed(
    input state_t s
  );
    return (s >= S_FILL_W) && (s <= S_SPIN);
  endfunction

  function automatic act_t decode(
    input state_t s
  );
    act_t a;
    a = '0;
    a.fill_valve = (s == S_FILL_W) ||
                   (s == S_FILL_R);
    a.agitate    = (s == S_WASH) ||
                   (s == S_RINSE);
    a.drain_pump = (s == S_DRAIN_W) ||
                   (s == S_DRAIN_R) ||
                   (s == S_SPIN);
    a.spin_motor = (s == S_SPIN);
    a.door_lock  = (s != S_IDLE) &&
                   (s != S_DONE);
    a.done       = (s == S_DONE);
    return a;
  endfunction

endpackage

// File: rtl/washer_tmr_arm.sv
// Timer restart pulse generator with stale-flag guard.
// 'armed' rises ARM_CYC cycles after tmr_rst falls.
module washer_tmr_arm #(
  parameter int ARM_CYC = 2
) (
  input  logic clk,
  input  logic R,
  input  logic enter,
  output logic tmr_rst,
  output logic armed
);

  localparam int W =
    (ARM_CYC < 1) ? 1 : $clog2(ARM_CYC + 1);
  localparam logic [W-1:0] LAST = W'(ARM_CYC);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      tmr_rst <= 1'b1;
      cnt_q   <= '0;
    end else if (enter) begin
      tmr_rst <= 1'b1;
      cnt_q   <= '0;
    end else begin
      tmr_rst <= 1'b0;
      // count only once the restart pulse is over
      if (!tmr_rst && (cnt_q != LAST))
        cnt_q <= cnt_q + W'(1);
    end
  end

  assign armed = !tmr_rst && (cnt_q == LAST);

endmodule

// File: rtl/washer_controller.sv
// Wash-cycle sequencing FSM; consumer of washerTimer done flags.
// Outputs are registered from the next state (Moore).
module washer_controller
  import washer_pkg::*;
#(
  parameter int NUM_RINSE = 1,
  parameter int ARM_CYC   = 2
) (
  input  logic       clk,
  input  logic       R,
  input  logic       start,
  input  logic       lid_closed,
  input  logic [1:0] cycle_sel,
  input  logic       Tf,
  input  logic       Tw,
  input  logic       Td,
  input  logic       Tr,
  input  logic       Ts,
  output logic       tmr_rst,
  output logic [1:0] tmr_load,
  output logic       fill_valve,
  output logic       agitate,
  output logic       drain_pump,
  output logic       spin_motor,
  output logic       door_lock,
  output logic       done,
  output logic [3:0] state_o
);

  state_t     state_q, state_d;
  state_t     resume_q, resume_d;
  logic [1:0] rinse_q, rinse_d;
  logic [1:0] load_q, load_d;
  act_t       act_q;
  logic       armed;
  logic       restart;
  logic       last_rinse;

  assign last_rinse =
    ({1'b0, rinse_q} + 3'd1) >= 3'(NUM_RINSE);

  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    rinse_d  = rinse_q;
    load_d   = load_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && lid_closed) begin
          state_d = S_FILL_W;
          load_d  = load_of(cycle_sel);
          rinse_d = '0;
        end
      end
      S_DONE: begin
        if (!start)
          state_d = S_IDLE;
      end
      S_PAUSE: begin
        if (lid_closed)
          state_d = resume_q;
      end
      default: begin
        // lid open beats any timer flag
        if (!lid_closed) begin
          state_d  = S_PAUSE;
          resume_d = state_q;
        end else if (armed) begin
          case (state_q)
            S_FILL_W:
              if (Tf) state_d = S_WASH;
            S_WASH:
              if (Tw) state_d = S_DRAIN_W;
            S_DRAIN_W:
              if (Td) state_d = S_FILL_R;
            S_FILL_R:
              if (Tf) state_d = S_RINSE;
            S_RINSE:
              if (Tr) state_d = S_DRAIN_R;
            S_DRAIN_R:
              if (Td) begin
                rinse_d = rinse_q + 2'd1;
                state_d = last_rinse ?
                          S_SPIN : S_FILL_R;
              end
            S_SPIN:
              if (Ts) state_d = S_DONE;
            default: ;
          endcase
        end
      end
    endcase
  end

  // hold restart in idle/done/pause, pulse on each timed entry
  assign restart = !timed(state_d) ||
                   (state_d != state_q);

  washer_tmr_arm #(
    .ARM_CYC (ARM_CYC)
  ) u_arm (
    .clk     (clk),
    .R       (R),
    .enter   (restart),
    .tmr_rst (tmr_rst),
    .armed   (armed)
  );

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      state_q  <= S_IDLE;
      resume_q <= S_IDLE;
      rinse_q  <= '0;
      load_q   <= LOAD_SMALL;
      act_q    <= '0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      rinse_q  <= rinse_d;
      load_q   <= load_d;
      act_q    <= decode(state_d);
    end
  end

  assign tmr_load   = load_q;
  assign fill_valve = act_q.fill_valve;
  assign agitate    = act_q.agitate;
  assign drain_pump = act_q.drain_pump;
  assign spin_motor = act_q.spin_motor;
  assign door_lock  = act_q.door_lock;
  assign done       = act_q.done;
  assign state_o    = state_q;

endmodule

// File: tb/tb_washer_controller.sv
// Scoreboard bench for washer_controller with stub timers.
// Two instances: NUM_RINSE=1 and NUM_RINSE=2.
module tb_washer_controller;
  import washer_pkg::*;

  localparam int ARM = 2;
  localparam int N   = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       R;
  logic [1:0] cycle_sel;
  logic       start0, lid0, force_tf;
  logic       start1, lid1;

  logic       rst0, fill0, agit0, drain0;
  logic       spin0, lock0, done0;
  logic [1:0] load0;
  logic [3:0] st0;
  logic       rst1, fill1, agit1, drain1;
  logic       spin1, lock1, done1;
  logic [1:0] load1;
  logic [3:0] st1;

  int   tc0, tc1;
  logic fl0, fl1, tf0;

  always @(posedge clk or posedge R)
    if (R)         tc0 <= 0;
    else if (rst0) tc0 <= 0;
    else if (tc0 < N) tc0 <= tc0 + 1;

  always @(posedge clk or posedge R)
    if (R)         tc1 <= 0;
    else if (rst1) tc1 <= 0;
    else if (tc1 < N) tc1 <= tc1 + 1;

  assign fl0 = !rst0 && (tc0 == N);
  assign fl1 = !rst1 && (tc1 == N);
  assign tf0 = fl0 | force_tf;

  washer_controller #(
    .NUM_RINSE (1),
    .ARM_CYC   (ARM)
  ) dut0 (
    .clk (clk), .R (R),
    .start (start0), .lid_closed (lid0),
    .cycle_sel (cycle_sel),
    .Tf (tf0), .Tw (fl0), .Td (fl0),
    .Tr (fl0), .Ts (fl0),
    .tmr_rst (rst0), .tmr_load (load0),
    .fill_valve (fill0), .agitate (agit0),
    .drain_pump (drain0), .spin_motor (spin0),
    .door_lock (lock0), .done (done0),
    .state_o (st0)
  );

  washer_controller #(
    .NUM_RINSE (2),
    .ARM_CYC   (ARM)
  ) dut1 (
    .clk (clk), .R (R),
    .start (start1), .lid_closed (lid1),
    .cycle_sel (cycle_sel),
    .Tf (fl1), .Tw (fl1), .Td (fl1),
    .Tr (fl1), .Ts (fl1),
    .tmr_rst (rst1), .tmr_load (load1),
    .fill_valve (fill1), .agitate (agit1),
    .drain_pump (drain1), .spin_motor (spin1),
    .door_lock (lock1), .done (done1),
    .state_o (st1)
  );

  int asserts = 0;
  int fails   = 0;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    asserts++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  logic [3:0] q0[$];
  logic [3:0] q1[$];
  logic [1:0] xl0, xl1;
  bit         en0, en1;
  logic [3:0] prev0 = 4'd0;
  logic [3:0] prev1 = 4'd0;
  logic       prst0 = 1'b1;
  int         falls0 = 0;

  always @(negedge clk) begin
    if (prst0 && !rst0) falls0++;
    prst0 = rst0;
    if (st0 !== prev0) begin
      if (en0) begin
        if (q0.size() == 0)
          check("seq0_extra", q0.size(), 1);
        else
          check("seq0", st0, q0.pop_front());
        if (st0 >= 1 && st0 <= 8)
          check("load0", load0, xl0);
        if (st0 == 8)
          check("done0", done0, 1);
        if ((st0 >= 1 && st0 <= 7) || st0 == 9)
          check("lock0", lock0, 1);
      end
      prev0 = st0;
    end
  end

  always @(negedge clk) begin
    if (st1 !== prev1) begin
      if (en1) begin
        if (q1.size() == 0)
          check("seq1_extra", q1.size(), 1);
        else
          check("seq1", st1, q1.pop_front());
        if (st1 >= 1 && st1 <= 8)
          check("load1", load1, xl1);
        if (st1 == 8)
          check("done1", done1, 1);
      end
      prev1 = st1;
    end
  end

  task automatic push_seq(
    input int inst,
    input int nr
  );
    logic [3:0] s[$];
    s = {4'd1, 4'd2, 4'd3};
    for (int k = 0; k < nr; k++)
      s = {s, 4'd4, 4'd5, 4'd6};
    s = {s, 4'd7, 4'd8, 4'd0};
    foreach (s[k])
      if (inst == 0) q0.push_back(s[k]);
      else           q1.push_back(s[k]);
  endtask

  task automatic pulse0();
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic pulse1();
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic wait_empty(
    input int    inst,
    input string tag
  );
    int n;
    for (int i = 0; i < 2000; i++) begin
      n = (inst == 0) ? q0.size() : q1.size();
      if (n == 0) break;
      @(negedge clk);
    end
    n = (inst == 0) ? q0.size() : q1.size();
    check(tag, n, 0);
  endtask

  task automatic wait_st(
    input int         inst,
    input logic [3:0] s,
    input string      tag
  );
    logic [3:0] cur;
    for (int i = 0; i < 500; i++) begin
      cur = (inst == 0) ? st0 : st1;
      if (cur == s) break;
      @(negedge clk);
    end
    cur = (inst == 0) ? st0 : st1;
    check(tag, cur, s);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  int         base;
  int         dur;
  bit         found;
  logic [3:0] pseq[$];

  initial begin
    R = 1'b1;
    start0 = 0; start1 = 0;
    lid0 = 1; lid1 = 1;
    force_tf = 0;
    cycle_sel = 2'b00;
    en0 = 0; en1 = 0;
    xl0 = 2'b00; xl1 = 2'b00;
    #100;
    @(negedge clk);
    R = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_tmr_rst", rst0, 1);
    check("rst_state", st0, 0);
    check("rst_act",
          {fill0, agit0, drain0, spin0}, 0);
    check("rst_lock", lock0, 0);
    check("rst_done", done0, 0);
    check("rst_load", load0, 0);
    check("rst_inst1",
          {st1, fill1, agit1, drain1, spin1,
           lock1, done1, rst1}, 1);

    // normal run, medium load
    cycle_sel = 2'b01;
    xl0 = 2'b01;
    en0 = 1;
    base = falls0;
    push_seq(0, 1);
    pulse0();
    wait_empty(0, "run1_complete");
    check("run1_rst_pulses", falls0 - base, 7);
    check("run1_idle_done", done0, 0);

    // stale fill flag held across entry
    force_tf = 1'b1;
    push_seq(0, 1);
    pulse0();
    dur = 0;
    for (int i = 0; i < 50; i++) begin
      if (st0 != 4'd1) break;
      dur++;
      @(negedge clk);
    end
    force_tf = 1'b0;
    check("stale_fillw_len",
          32'(dur >= ARM + 1), 1);
    wait_empty(0, "run2_complete");

    // lid opens exactly as wash flag rises
    cycle_sel = 2'b10;
    xl0 = 2'b10;
    pseq = {4'd1, 4'd2, 4'd9, 4'd2, 4'd3,
            4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
            4'd0};
    foreach (pseq[k]) q0.push_back(pseq[k]);
    pulse0();
    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (st0 == 4'd2 && fl0) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("pause_flag_seen", found, 1);
    lid0 = 1'b0;
    @(negedge clk);
    check("pause_state", st0, 9);
    check("pause_agit", agit0, 0);
    check("pause_lock", lock0, 1);
    check("pause_tmr_rst", rst0, 1);
    repeat (3) @(negedge clk);
    lid0 = 1'b1;
    @(negedge clk);
    check("resume_state", st0, 2);
    check("resume_tmr_hi", rst0, 1);
    check("resume_agit", agit0, 1);
    @(negedge clk);
    check("resume_tmr_lo", rst0, 0);
    wait_empty(0, "run3_complete");

    // two rinses, cycle_sel wiggled mid-run
    cycle_sel = 2'b10;
    xl1 = 2'b10;
    en1 = 1;
    push_seq(1, 2);
    pulse1();
    wait_st(1, 4'd3, "r2_reach_drain_w");
    cycle_sel = 2'b00;
    wait_st(1, 4'd5, "r2_reach_rinse");
    cycle_sel = 2'b11;
    check("r2_mid_load", load1, 2'b10);
    wait_empty(1, "run4_complete");

    // async reset during spin
    cycle_sel = 2'b11;
    xl0 = 2'b10;
    push_seq(0, 1);
    pulse0();
    wait_st(0, 4'd7, "r5_reach_spin");
    check("spin_on", spin0, 1);
    check("spin_drain_on", drain0, 1);
    en0 = 0;
    #2;
    q0.delete();
    R = 1'b1;
    #1;
    check("rst_spin", spin0, 0);
    check("rst_drain", drain0, 0);
    check("rst_lock_mid", lock0, 0);
    check("rst_state_mid", st0, 0);
    check("rst_tmr_mid", rst0, 1);
    @(negedge clk);
    R = 1'b0;
    @(negedge clk);
    cycle_sel = 2'b00;
    xl0 = 2'b00;
    en0 = 1;
    push_seq(0, 1);
    pulse0();
    wait_empty(0, "run6_complete");

    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end

endmodule
